// File: rtl/mfr_pkg.sv
// Shared opcode and FSM state definitions for the multifunction register.
package mfr_pkg;

    localparam logic [2:0] OP_HOLD  = 3'd0;
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_CLEAR = 3'd2;
    localparam logic [2:0] OP_INC   = 3'd3;
    localparam logic [2:0] OP_DEC   = 3'd4;
    localparam logic [2:0] OP_SHL   = 3'd5;
    localparam logic [2:0] OP_SHR   = 3'd6;
    localparam logic [2:0] OP_ROL   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/mfr_step.sv
// One update of the register: full single-cycle op, or a single 1-bit shift/rotate step.
module mfr_step
    import mfr_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [2:0]   op,
    input  logic [W-1:0] outr,
    input  logic [W-1:0] operand,
    output logic [W-1:0] result,
    output logic         carry
);

    always_comb begin
        result = outr;
        carry  = 1'b0;
        case (op)
            OP_LOAD:  result = operand;
            OP_CLEAR: result = '0;
            OP_INC:   {carry, result} = {1'b0, outr} + (W+1)'(1);
            OP_DEC: begin
                result = outr - W'(1);
                carry  = (outr == '0);
            end
            OP_SHL: begin
                result = {outr[W-2:0], 1'b0};
                carry  = outr[W-1];
            end
            OP_SHR: begin
                result = {1'b0, outr[W-1:1]};
                carry  = outr[0];
            end
            OP_ROL: begin
                result = {outr[W-2:0], outr[W-1]};
                carry  = outr[W-1];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/nw_multifunction_register.sv
// W-bit multifunction register with soc/eoc handshake; shifts and rotates run one bit per clock.
module nw_multifunction_register
    import mfr_pkg::*;
#(
    parameter int W  = 8,
    parameter int AW = $clog2(W)
) (
    input  logic          clock,
    input  logic          reset_,
    input  logic          soc,
    input  logic [2:0]    b,
    input  logic [W-1:0]  x,
    input  logic [AW-1:0] amt,
    output logic          eoc,
    output logic [W-1:0]  z,
    output logic          cout
);

    state_t        state, state_nx;
    logic [W-1:0]  outr, outr_nx;
    logic          cout_r, cout_nx;
    logic [AW-1:0] cnt, cnt_nx;
    logic [2:0]    op, op_nx;
    logic [W-1:0]  opnd, opnd_nx;

    logic [W-1:0]  step_val;
    logic          step_c;
    logic          is_shift;

    mfr_step #(.W(W)) u_step (
        .op      (op),
        .outr    (outr),
        .operand (opnd),
        .result  (step_val),
        .carry   (step_c)
    );

    assign is_shift = (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL);

    always_comb begin
        state_nx = state;
        outr_nx  = outr;
        cout_nx  = cout_r;
        cnt_nx   = cnt;
        op_nx    = op;
        opnd_nx  = opnd;
        case (state)
            S_IDLE: begin
                if (soc) begin
                    op_nx    = b;
                    opnd_nx  = x;
                    cnt_nx   = amt;
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (!is_shift) begin
                    outr_nx  = step_val;
                    cout_nx  = step_c;
                    state_nx = S_WAIT;
                end else if (cnt == '0) begin
                    // zero-length shift: register untouched, carry cleared
                    cout_nx  = 1'b0;
                    state_nx = S_WAIT;
                end else begin
                    outr_nx = step_val;
                    cout_nx = step_c;
                    cnt_nx  = cnt - AW'(1);
                    if (cnt == AW'(1))
                        state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!soc)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state  <= S_IDLE;
            outr   <= '0;
            cout_r <= 1'b0;
            cnt    <= '0;
        end else begin
            state  <= state_nx;
            outr   <= outr_nx;
            cout_r <= cout_nx;
            cnt    <= cnt_nx;
        end
    end

    // Latched command operands are only consumed in RUN, so they need no reset.
    always_ff @(posedge clock) begin
        op   <= op_nx;
        opnd <= opnd_nx;
    end

    assign eoc  = (state == S_IDLE);
    assign z    = outr;
    assign cout = cout_r;

endmodule

// File: doc/nw_multifunction_register.md
Name: nw_multifunction_register

Overview:
- W-bit multifunction register driven by an 8-opcode command set. Commands are issued over a soc/eoc handshake.
- Shift and rotate opcodes execute over multiple cycles, one bit position per clock. A small FSM sequences them.
- Generalises the fixed 4-bit, single-cycle multifunction register: width is a parameter, the block adds carry-out, and commands are multi-cycle with a handshake.
- Used as a datapath register under a handshaking controller.

Parameters:
- W, 8, register width in bits (W >= 2).
- AW, $clog2(W), width of the shift-amount port (derived; do not override).

Ports:
- clock  input  1  system clock, rising edge.
- reset_  input  1  asynchronous, active-low reset.
- soc  input  1  start of command; level signal, part of the handshake.
- b  input  3  opcode, sampled with soc.
- x  input  W  data operand, sampled with soc.
- amt  input  AW  shift/rotate amount, 0..W-1, sampled with soc.
- eoc  output  1  end of command; 1 = idle/ready.
- z  output  W  register contents (OUTR).
- cout  output  1  carry, borrow or last shifted-out bit.

Behaviour:
- Reset: reset_=0 asynchronously forces OUTR=0, cout=0, state=IDLE, eoc=1, step counter=0. This holds mid-operation; a partially shifted value is discarded. Release is synchronous to the next clock edge.
- Opcodes (b):
  - 0 HOLD: no change.
  - 1 LOAD: OUTR<=x.
  - 2 CLEAR: OUTR<=0.
  - 3 INC: {cout,OUTR}<=OUTR+1, mod 2^W.
  - 4 DEC: OUTR<=OUTR-1, mod 2^W; cout=borrow (1 only when OUTR was 0).
  - 5 SHL: shift left, serial-in 0.
  - 6 SHR: logical shift right, serial-in 0.
  - 7 ROL: rotate left.
- cout for shifts/rotates is the last bit moved out of the MSB (SHL/ROL) or the LSB (SHR).
- cout for HOLD/LOAD/CLEAR is 0.
- cout is held until the next command's first update.
- States:
  - IDLE: eoc=1. At a rising edge with soc=1: latch b, x and amt into internal regs; set cnt=amt; go to RUN.
  - RUN: eoc=0.
    - Opcodes 0-4 perform their single update at the first RUN edge, then go to WAIT.
    - Opcodes 5-7 perform one 1-bit step per edge while cnt>0, decrementing cnt. When cnt reaches 0 they go to WAIT.
    - Shift/rotate with amt=0 makes no change to OUTR, sets cout=0, and goes to WAIT after 1 cycle.
  - WAIT: eoc=0. At an edge with soc=0, go to IDLE. soc held at 1 keeps the block in WAIT.
- Latency from the soc-sampling edge to the OUTR update:
  - Single-cycle ops: 1 clock.
  - Shift/rotate by n: max(n,1) clocks.
  - eoc returns to 1 one edge after soc is seen low in WAIT.
- b, x and amt are don't-care outside the soc-sampling edge; changes during RUN have no effect.
- soc=1 in RUN is ignored. A new command needs soc to fall (WAIT to IDLE) and then rise again.
- z always reflects OUTR directly. There is no combinational path from the inputs to z or eoc.

Decomposition:
- Package mfr_pkg:
  - opcode localparams OP_HOLD..OP_ROL (3-bit);
  - state encoding S_IDLE/S_RUN/S_WAIT (2-bit).
- Sub-module mfr_step (combinational):
  - inputs: opcode, OUTR;
  - outputs: next OUTR and cout for one step.
  - The FSM in nw_multifunction_register calls it once per RUN cycle.

Test Plan (W=8):
- Reset, then LOAD x=8'hA5 with soc pulse; hold soc until eoc=0, then drop it -> z=8'hA5 one edge after sampling; eoc=0 then back to 1; cout=0.
- OUTR=8'hFF, INC -> z=8'h00, cout=1. Then DEC -> z=8'hFF, cout=1 (borrow).
- OUTR=8'b1001_0110, SHL amt=3 -> z after edges 1,2,3 = 2C, 58, B0. cout=0 after the final step; eoc=0 for all 3 RUN cycles.
- OUTR=8'h81, ROL amt=7 -> z=8'hC0 after 7 RUN cycles, cout=0. Repeat with SHR amt=0 -> z unchanged, 1 RUN cycle, cout=0.
- Assert reset_=0 asynchronously (mid-clock) during the 2nd step of SHR amt=5 -> z=0, eoc=1 immediately. After release, the first soc starts a fresh command.
- Keep soc=1 across completion -> block stays in WAIT with eoc=0 and issues no second command. Change b/x during RUN -> result unaffected.
